fifo_wr_ptr_full: RTL and testbench

//   Write-side pointer and status controller of the async FIFO, wclk domain.

---
 rtl/fifo_wr_ptr_full_if.sv | 27 ++
 rtl/fifo_wr_ptr_full.sv | 61 ++++++
 tb/tb_fifo_wr_ptr_full.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_ptr_full_if.sv
// fifo_wr_ptr_full_if: write-side bus of the async FIFO pointer/status controller
//   master: producer side; drives winc, wq2_rptr, wovf_clr
//   slave : controller side; drives waddr, wclken, wptr, wfull, walmost_full, wfill, wovf
interface fifo_wr_ptr_full_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                    winc;
    logic [ADDR_WIDTH-1:0]   wq2_rptr;
    logic                    wovf_clr;
    logic [ADDR_WIDTH-2:0]   waddr;
    logic                    wclken;
    logic [ADDR_WIDTH-1:0]   wptr;
    logic                    wfull;
    logic                    walmost_full;
    logic [ADDR_WIDTH-1:0]   wfill;
    logic                    wovf;

    modport master (
        output winc, wq2_rptr, wovf_clr,
        input  waddr, wclken, wptr, wfull, walmost_full, wfill, wovf
    );

    modport slave (
        input  winc, wq2_rptr, wovf_clr,
        output waddr, wclken, wptr, wfull, walmost_full, wfill, wovf
    );
endinterface

// File: rtl/fifo_wr_ptr_full.sv
// fifo_wr_ptr_full: async FIFO write-side pointer, full/almost-full, fill level and sticky overflow
//   wclk   : write clock
//   wrst_n : async active-low reset
//   bus    : slave side of fifo_wr_ptr_full_if
//            in : winc, wq2_rptr (Gray, already synchronized to wclk), wovf_clr
//            out: waddr, wclken, wptr (registered Gray), wfull, walmost_full, wfill, wovf
module fifo_wr_ptr_full #(
    parameter int FIFO_DEPTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 6
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    fifo_wr_ptr_full_if.slave    bus
);
    localparam int AW = ADDR_WIDTH;
    localparam logic [AW-1:0] DEPTH = FIFO_DEPTH[AW-1:0];
    localparam logic [AW-1:0] AFULL = AFULL_THRESH[AW-1:0];

    logic [AW-1:0] wbin;
    logic [AW-1:0] wbin_next;
    logic [AW-1:0] wgray_next;
    logic [AW-1:0] rbin_s;
    logic [AW-1:0] fill_next;
    logic          wfull_next;

    always_comb begin
        // gated by reset so no write strobe reaches memory while held in reset
        bus.wclken = bus.winc & ~bus.wfull & wrst_n;
        wbin_next  = wbin + {{(AW-1){1'b0}}, bus.wclken};
        wgray_next = wbin_next ^ (wbin_next >> 1);
        rbin_s     = '0;
        for (int i = 0; i < AW; i++)
            rbin_s[i] = ^(bus.wq2_rptr >> i);
        fill_next  = wbin_next - rbin_s;
        // full when write pointer has lapped read pointer: top two Gray bits inverted
        wfull_next = (wgray_next == {~bus.wq2_rptr[AW-1:AW-2], bus.wq2_rptr[AW-3:0]});
    end

    assign bus.waddr = wbin[AW-2:0];

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin             <= '0;
            bus.wptr         <= '0;
            bus.wfull        <= 1'b0;
            bus.walmost_full <= 1'b0;
            bus.wfill        <= '0;
            bus.wovf         <= 1'b0;
        end else begin
            wbin             <= wbin_next;
            bus.wptr         <= wgray_next;
            bus.wfull        <= wfull_next;
            bus.walmost_full <= fill_next >= AFULL;
            // clamp guards against a corrupted synchronized read pointer
            bus.wfill        <= (fill_next > DEPTH) ? DEPTH : fill_next;
            // a rejected write wins over a same-cycle clear
            bus.wovf         <= (bus.winc & bus.wfull) ? 1'b1 : bus.wovf_clr ? 1'b0 : bus.wovf;
        end
    end
endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// tb_fifo_wr_ptr_full: directed self-checking bench for fifo_wr_ptr_full
//   drives the master side of fifo_wr_ptr_full_if; checks registered outputs 1 time unit after wclk rise
module tb_fifo_wr_ptr_full;
    logic wclk = 1'b0;
    logic wrst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fifo_wr_ptr_full_if #(.ADDR_WIDTH(4)) bus ();

    fifo_wr_ptr_full #(.FIFO_DEPTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(6)) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    always #5 wclk = ~wclk;

    task automatic edge_step();
        @(posedge wclk);
        #1;
    endtask

    task automatic pulse_reset();
        wrst_n = 1'b0;
        #1;
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        wrst_n = 1'b0;
        bus.winc = 1'b0;
        bus.wq2_rptr = 4'd0;
        bus.wovf_clr = 1'b0;
        repeat (2) edge_step();
        checks++; if (bus.waddr !== 3'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", bus.waddr); end
        checks++; if (bus.wclken !== 1'b0) begin errors++; $display("FAIL reset_wclken got %b want 0", bus.wclken); end
        checks++; if (bus.wptr !== 4'd0) begin errors++; $display("FAIL reset_wptr got %b want 0000", bus.wptr); end
        checks++; if (bus.wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull got %b want 0", bus.wfull); end
        checks++; if (bus.walmost_full !== 1'b0) begin errors++; $display("FAIL reset_afull got %b want 0", bus.walmost_full); end
        checks++; if (bus.wfill !== 4'd0) begin errors++; $display("FAIL reset_wfill got %0d want 0", bus.wfill); end
        checks++; if (bus.wovf !== 1'b0) begin errors++; $display("FAIL reset_wovf got %b want 0", bus.wovf); end
        wrst_n = 1'b1;
    endtask

    task automatic test_fill();
        logic [3:0] gexp [8];
        logic [3:0] fexp [8];
        logic       aexp [8];
        logic       uexp [8];
        gexp = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
        fexp = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
        aexp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        uexp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.wq2_rptr = 4'd0;
        for (int i = 0; i < 8; i++) begin
            bus.winc = 1'b1;
            #1;
            checks++; if (bus.wclken !== 1'b1) begin errors++; $display("FAIL fill_wclken[%0d] got %b want 1", i, bus.wclken); end
            checks++; if (bus.waddr !== i[2:0]) begin errors++; $display("FAIL fill_waddr[%0d] got %0d want %0d", i, bus.waddr, i); end
            edge_step();
            checks++; if (bus.wptr !== gexp[i]) begin errors++; $display("FAIL fill_wptr[%0d] got %b want %b", i, bus.wptr, gexp[i]); end
            checks++; if (bus.wfill !== fexp[i]) begin errors++; $display("FAIL fill_wfill[%0d] got %0d want %0d", i, bus.wfill, fexp[i]); end
            checks++; if (bus.walmost_full !== aexp[i]) begin errors++; $display("FAIL fill_afull[%0d] got %b want %b", i, bus.walmost_full, aexp[i]); end
            checks++; if (bus.wfull !== uexp[i]) begin errors++; $display("FAIL fill_wfull[%0d] got %b want %b", i, bus.wfull, uexp[i]); end
        end
        bus.winc = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 3; i++) begin
            bus.winc = 1'b1;
            #1;
            checks++; if (bus.wclken !== 1'b0) begin errors++; $display("FAIL ovf_wclken[%0d] got %b want 0", i, bus.wclken); end
            checks++; if (bus.waddr !== 3'd0) begin errors++; $display("FAIL ovf_waddr[%0d] got %0d want 0", i, bus.waddr); end
            edge_step();
            checks++; if (bus.wovf !== 1'b1) begin errors++; $display("FAIL ovf_set[%0d] got %b want 1", i, bus.wovf); end
            checks++; if (bus.wptr !== 4'b1100) begin errors++; $display("FAIL ovf_wptr_hold[%0d] got %b want 1100", i, bus.wptr); end
        end
        bus.winc = 1'b0;
        bus.wovf_clr = 1'b1;
        edge_step();
        checks++; if (bus.wovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", bus.wovf); end
        bus.winc = 1'b1;
        edge_step();
        checks++; if (bus.wovf !== 1'b1) begin errors++; $display("FAIL ovf_set_beats_clr got %b want 1", bus.wovf); end
        bus.winc = 1'b0;
        edge_step();
        checks++; if (bus.wovf !== 1'b0) begin errors++; $display("FAIL ovf_clear2 got %b want 0", bus.wovf); end
        bus.wovf_clr = 1'b0;
    endtask

    task automatic test_release();
        bus.wq2_rptr = 4'b0010;
        bus.winc = 1'b0;
        edge_step();
        checks++; if (bus.wfull !== 1'b0) begin errors++; $display("FAIL rel_wfull got %b want 0", bus.wfull); end
        checks++; if (bus.wfill !== 4'd5) begin errors++; $display("FAIL rel_wfill got %0d want 5", bus.wfill); end
        checks++; if (bus.walmost_full !== 1'b0) begin errors++; $display("FAIL rel_afull got %b want 0", bus.walmost_full); end
        bus.winc = 1'b1;
        #1;
        checks++; if (bus.wclken !== 1'b1) begin errors++; $display("FAIL rel_wclken got %b want 1", bus.wclken); end
        edge_step();
        bus.winc = 1'b0;
        checks++; if (bus.wfill !== 4'd6) begin errors++; $display("FAIL rel_wfill6 got %0d want 6", bus.wfill); end
        checks++; if (bus.walmost_full !== 1'b1) begin errors++; $display("FAIL rel_afull6 got %b want 1", bus.walmost_full); end
        checks++; if (bus.wptr !== 4'b1101) begin errors++; $display("FAIL rel_wptr got %b want 1101", bus.wptr); end
        checks++; if (bus.waddr !== 3'd1) begin errors++; $display("FAIL rel_waddr got %0d want 1", bus.waddr); end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        bus.wq2_rptr = 4'd0;
        bus.winc = 1'b1;
        repeat (3) edge_step();
        checks++; if (bus.waddr !== 3'd3) begin errors++; $display("FAIL mid_pre_waddr got %0d want 3", bus.waddr); end
        wrst_n = 1'b0;
        #1;
        checks++; if (bus.waddr !== 3'd0) begin errors++; $display("FAIL mid_waddr got %0d want 0", bus.waddr); end
        checks++; if (bus.wclken !== 1'b0) begin errors++; $display("FAIL mid_wclken got %b want 0", bus.wclken); end
        checks++; if (bus.wptr !== 4'd0) begin errors++; $display("FAIL mid_wptr got %b want 0000", bus.wptr); end
        checks++; if (bus.wfill !== 4'd0) begin errors++; $display("FAIL mid_wfill got %0d want 0", bus.wfill); end
        wrst_n = 1'b1;
        #1;
        checks++; if (bus.wclken !== 1'b1) begin errors++; $display("FAIL mid_resume_wclken got %b want 1", bus.wclken); end
        edge_step();
        bus.winc = 1'b0;
        checks++; if (bus.wptr !== 4'b0001) begin errors++; $display("FAIL mid_resume_wptr got %b want 0001", bus.wptr); end
        checks++; if (bus.waddr !== 3'd1) begin errors++; $display("FAIL mid_resume_waddr got %0d want 1", bus.waddr); end
    endtask

    task automatic test_wrap();
        logic [3:0] b;
        logic [3:0] nb;
        pulse_reset();
        for (int i = 0; i < 20; i++) begin
            b = i[3:0];
            nb = b + 4'd1;
            bus.wq2_rptr = b ^ (b >> 1);
            bus.winc = 1'b1;
            #1;
            checks++; if (bus.waddr !== b[2:0]) begin errors++; $display("FAIL wrap_waddr[%0d] got %0d want %0d", i, bus.waddr, b[2:0]); end
            edge_step();
            checks++; if (bus.wptr !== (nb ^ (nb >> 1))) begin errors++; $display("FAIL wrap_wptr[%0d] got %b want %b", i, bus.wptr, nb ^ (nb >> 1)); end
            checks++; if (bus.wfull !== 1'b0) begin errors++; $display("FAIL wrap_wfull[%0d] got %b want 0", i, bus.wfull); end
            checks++; if (bus.wfill !== 4'd1) begin errors++; $display("FAIL wrap_wfill[%0d] got %0d want 1", i, bus.wfill); end
            if (i == 14) begin
                checks++; if (bus.wptr !== 4'b1000) begin errors++; $display("FAIL wrap_wptr15 got %b want 1000", bus.wptr); end
            end
            if (i == 15) begin
                checks++; if (bus.wptr !== 4'b0000) begin errors++; $display("FAIL wrap_wptr0 got %b want 0000", bus.wptr); end
            end
        end
        bus.winc = 1'b0;
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        bus.wq2_rptr = 4'd0;
        bus.winc = 1'b1;
        repeat (8) edge_step();
        checks++; if (bus.wfull !== 1'b1) begin errors++; $display("FAIL b2b_full got %b want 1", bus.wfull); end
        checks++; if (bus.wfill !== 4'd8) begin errors++; $display("FAIL b2b_fill got %0d want 8", bus.wfill); end
        bus.wq2_rptr = 4'b0001;
        #1;
        checks++; if (bus.wclken !== 1'b0) begin errors++; $display("FAIL b2b_wclken0 got %b want 0", bus.wclken); end
        edge_step();
        checks++; if (bus.wfull !== 1'b0) begin errors++; $display("FAIL b2b_release got %b want 0", bus.wfull); end
        checks++; if (bus.wfill !== 4'd7) begin errors++; $display("FAIL b2b_fill7 got %0d want 7", bus.wfill); end
        checks++; if (bus.wptr !== 4'b1100) begin errors++; $display("FAIL b2b_wptr_hold got %b want 1100", bus.wptr); end
        checks++; if (bus.wovf !== 1'b1) begin errors++; $display("FAIL b2b_wovf got %b want 1", bus.wovf); end
        #1;
        checks++; if (bus.wclken !== 1'b1) begin errors++; $display("FAIL b2b_wclken1 got %b want 1", bus.wclken); end
        checks++; if (bus.waddr !== 3'd0) begin errors++; $display("FAIL b2b_waddr got %0d want 0", bus.waddr); end
        edge_step();
        bus.winc = 1'b0;
        checks++; if (bus.wfull !== 1'b1) begin errors++; $display("FAIL b2b_refull got %b want 1", bus.wfull); end
        checks++; if (bus.wfill !== 4'd8) begin errors++; $display("FAIL b2b_fill8 got %0d want 8", bus.wfill); end
        checks++; if (bus.wptr !== 4'b1101) begin errors++; $display("FAIL b2b_wptr got %b want 1101", bus.wptr); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
